// File: rtl/ahb_lite_reg_slave.sv
// ahb_lite_reg_slave: AHB-Lite register bank with programmable wait states and ERROR response
module ahb_lite_reg_slave #(
    parameter int ADDR_W      = 32,
    parameter int NUM_REGS    = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   HSEL,
    input  logic [ADDR_W-1:0]      HADDR,
    input  logic [1:0]             HTRANS,
    input  logic                   HWRITE,
    input  logic [2:0]             HSIZE,
    input  logic [2:0]             HBURST,
    input  logic [3:0]             HPROT,
    input  logic                   HMASTLOCK,
    input  logic [31:0]            HWDATA,
    input  logic                   HREADY,
    output logic [31:0]            HRDATA,
    output logic                   HREADYOUT,
    output logic                   HRESP,
    output logic [32*NUM_REGS-1:0] reg_o,
    output logic [NUM_REGS-1:0]    wr_strobe_o
);
    localparam int IDX_W = $clog2(NUM_REGS);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [1:0]          off_q, off_d;
    logic [2:0]          size_q, size_d;
    logic                write_q, write_d;
    logic [NUM_REGS-1:0] strobe_q, strobe_d;
    logic [31:0]         regs_q [NUM_REGS];
    logic                accept, addr_err, commit;
    logic [31:0]         lane_mask, wr_word;
    logic                unused_inputs;

    assign unused_inputs = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    assign accept   = HSEL & HREADY & HTRANS[1];
    assign addr_err = (HADDR >= ADDR_W'(4 * NUM_REGS)) | (HSIZE > 3'd2) |
                      ((HSIZE == 3'd1) & HADDR[0]) |
                      ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));
    assign commit   = (state_q == S_DATA) & write_q;

    // Data-phase sequencing; IDLE, DATA and ERR2 all take a new address phase the same way
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        off_d   = off_q;
        size_d  = size_q;
        write_d = write_q;
        case (state_q)
            S_WAIT: begin
                state_d = (cnt_q == 4'd0) ? S_DATA : S_WAIT;
                cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                state_d = S_IDLE;
                if (accept) begin
                    idx_d   = HADDR[IDX_W+1:2];
                    off_d   = HADDR[1:0];
                    size_d  = HSIZE;
                    write_d = HWRITE;
                    state_d = addr_err ? S_ERR1 : ((WAIT_STATES == 0) ? S_DATA : S_WAIT);
                    cnt_d   = addr_err ? 4'd0 : 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
                end
            end
        endcase
    end

    // Byte-lane enables of the transfer in its data phase, merged with the current word
    always_comb begin
        lane_mask = '0;
        for (int b = 0; b < 4; b++)
            lane_mask[8*b +: 8] = {8{(size_q == 3'd2) |
                                     ((size_q == 3'd1) & (2'(b) >> 1 == {1'b0, off_q[1]})) |
                                     ((size_q == 3'd0) & (2'(b) == off_q))}};
        wr_word  = (HWDATA & lane_mask) | (regs_q[idx_q] & ~lane_mask);
        strobe_d = commit ? ({{(NUM_REGS-1){1'b0}}, 1'b1} << idx_q) : '0;
    end

    // Control state; a reset anywhere drops the transfer in flight
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            off_q    <= 2'd0;
            size_q   <= 3'd0;
            write_q  <= 1'b0;
            strobe_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            off_q    <= off_d;
            size_q   <= size_d;
            write_q  <= write_d;
            strobe_q <= strobe_d;
        end
    end

    // Register bank; writes land on the edge that completes the OKAY data phase
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else if (commit) begin
            regs_q[idx_q] <= wr_word;
        end
    end

    assign HREADYOUT   = (state_q != S_WAIT) & (state_q != S_ERR1);
    assign HRESP       = (state_q == S_ERR1) | (state_q == S_ERR2);
    assign HRDATA      = ((state_q == S_DATA) & ~write_q) ? regs_q[idx_q] : '0;
    assign wr_strobe_o = strobe_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        assign reg_o[32*i +: 32] = regs_q[i];
    end
endmodule

// File: tb/tb_ahb_lite_reg_slave.sv
// tb_ahb_lite_reg_slave: two slaves (0 and 3 wait states) driven by a pipelined master vs a register-array model
module tb_ahb_lite_reg_slave;
    localparam int NR = 16;

    int n_cmp = 0, n_bad = 0;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]            rstn, hsel, hwrite, hrdy_lo, hready, hreadyout, hresp;
    logic [1:0][31:0]      haddr, hwdata, hrdata;
    logic [1:0][1:0]       htrans;
    logic [1:0][2:0]       hsize;
    logic [1:0][32*NR-1:0] rego;
    logic [1:0][NR-1:0]    strobe;

    assign hready = hreadyout & ~hrdy_lo;

    ahb_lite_reg_slave #(.ADDR_W(32), .NUM_REGS(NR), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESETn(rstn[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(3'd1), .HPROT(4'd3), .HMASTLOCK(1'b0),
        .HWDATA(hwdata[0]), .HREADY(hready[0]), .HRDATA(hrdata[0]), .HREADYOUT(hreadyout[0]),
        .HRESP(hresp[0]), .reg_o(rego[0]), .wr_strobe_o(strobe[0]));

    ahb_lite_reg_slave #(.ADDR_W(32), .NUM_REGS(NR), .WAIT_STATES(3)) dut3 (
        .HCLK(clk), .HRESETn(rstn[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(3'd0), .HPROT(4'd0), .HMASTLOCK(1'b1),
        .HWDATA(hwdata[1]), .HREADY(hready[1]), .HRDATA(hrdata[1]), .HREADYOUT(hreadyout[1]),
        .HRESP(hresp[1]), .reg_o(rego[1]), .wr_strobe_o(strobe[1]));

    logic [31:0] mem [2][NR];
    logic        t_wr [8];
    logic [31:0] t_addr [8];
    int          t_size [8];
    logic [31:0] t_wd [8];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic int wait_of(input int d);
        return d == 0 ? 0 : 3;
    endfunction

    function automatic logic is_err(input logic [31:0] a, input int sz);
        return a >= 32'(4 * NR) || sz > 2 || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [31:0] a, input int sz);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (sz == 2 || (sz == 1 && b / 2 == (a / 2) % 2) || (sz == 0 && b == a % 4))
                r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic check_regs(input int d);
        for (int i = 0; i < NR; i++) check("reg", rego[d][32*i +: 32], mem[d][i]);
    endtask

    task automatic drive_addr(input int d, input int k, input int n);
        if (k < n) begin
            hsel[d] = 1'b1; htrans[d] = 2'd2; haddr[d] = t_addr[k];
            hwrite[d] = t_wr[k]; hsize[d] = 3'(t_size[k]);
        end else begin
            hsel[d] = 1'b0; htrans[d] = 2'd0; haddr[d] = '0; hwrite[d] = 1'b0; hsize[d] = 3'd0;
        end
    endtask

    task automatic run_seq(input int d, input int n);
        logic err;
        int waits, idx;
        logic [NR-1:0] prev_st = '0;
        drive_addr(d, 0, n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            hwdata[d] = t_wd[k];
            drive_addr(d, k + 1, n);
            check("strobe", strobe[d], prev_st);
            err = is_err(t_addr[k], t_size[k]);
            idx = int'((t_addr[k] >> 2) % NR);
            waits = 0;
            while (!hreadyout[d] && waits < 20) begin
                check("wait_hresp", hresp[d], err);
                check("wait_hrdata", hrdata[d], 0);
                @(posedge clk); #1;
                waits++;
                check("strobe_pulse", strobe[d], 0);
            end
            check("waits", waits, err ? 1 : wait_of(d));
            check("hresp", hresp[d], err);
            check("hrdata", hrdata[d], (!err && !t_wr[k]) ? mem[d][idx] : 32'h0);
            if (t_wr[k] && !err) mem[d][idx] = merge(mem[d][idx], t_wd[k], t_addr[k], t_size[k]);
            prev_st = (t_wr[k] && !err) ? NR'(1) << idx : '0;
        end
        @(posedge clk); #1;
        hwdata[d] = $urandom;
        check("strobe_last", strobe[d], prev_st);
        check("idle_ready", hreadyout[d], 1);
        @(posedge clk); #1;
        check("strobe_clear", strobe[d], 0);
        check_regs(d);
    endtask

    task automatic set_t(input int k, input logic wr, input logic [31:0] a, input int sz,
                         input logic [31:0] wd);
        t_wr[k] = wr; t_addr[k] = a; t_size[k] = sz; t_wd[k] = wd;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 2; d++) for (int i = 0; i < NR; i++) mem[d][i] = '0;
        rstn = '0; hsel = '0; hwrite = '0; hrdy_lo = '0; haddr = '0; hwdata = '0;
        htrans = '0; hsize = '0;
        repeat (3) @(posedge clk);
        #1 rstn = 2'b11;
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", hreadyout[d], 1);
            check("rst_resp", hresp[d], 0);
            check("rst_rdata", hrdata[d], 0);
            check("rst_strobe", strobe[d], 0);
            check("rst_regs", rego[d], 0);
        end

        set_t(0, 1, 32'h08, 2, 32'hDEADBEEF);
        set_t(1, 0, 32'h08, 2, 32'h0);
        run_seq(0, 2);
        check("t1_reg2", rego[0][95:64], 32'hDEADBEEF);

        set_t(0, 1, 32'h0C, 2, 32'h11223344);
        set_t(1, 1, 32'h0D, 0, 32'hAAAAAAAA);
        run_seq(0, 2);
        check("byte_lane", rego[0][127:96], 32'h1122AA44);
        set_t(0, 1, 32'h0E, 1, 32'h55665566);
        set_t(1, 0, 32'h0C, 2, 32'h0);
        run_seq(0, 2);
        check("half_lane", rego[0][127:96], 32'h5566AA44);

        set_t(0, 1, 32'h00, 2, 32'h1);
        set_t(1, 0, 32'h00, 2, 32'h0);
        run_seq(1, 2);
        check("ws3_reg0", rego[1][31:0], 32'h1);

        for (int d = 0; d < 2; d++) begin
            set_t(0, 1, 32'h40, 2, 32'hFFFFFFFF);
            set_t(1, 1, 32'h02, 2, 32'hFFFFFFFF);
            set_t(2, 0, 32'h3C, 3, 32'h0);
            run_seq(d, 3);
        end

        for (int c = 0; c < 3; c++) begin
            hsel[0] = (c != 1); htrans[0] = (c == 0) ? 2'd1 : 2'd2; hrdy_lo[0] = (c == 2);
            haddr[0] = 32'h0; hwrite[0] = 1'b1; hsize[0] = 3'd2;
            @(posedge clk); #1;
            hsel[0] = 1'b0; htrans[0] = 2'd0; hrdy_lo[0] = 1'b0; hwdata[0] = 32'hFFFFFFFF;
            check("noacc_ready", hreadyout[0], 1);
            check("noacc_resp", hresp[0], 0);
            @(posedge clk); #1;
            check("noacc_strobe", strobe[0], 0);
            check("noacc_reg0", rego[0][31:0], mem[0][0]);
        end

        hsel[1] = 1'b1; htrans[1] = 2'd2; haddr[1] = 32'h04; hwrite[1] = 1'b1; hsize[1] = 3'd2;
        @(posedge clk); #1;
        hsel[1] = 1'b0; htrans[1] = 2'd0; hwdata[1] = 32'hCAFEF00D;
        check("midwait_low", hreadyout[1], 0);
        #1 rstn[1] = 1'b0;
        for (int i = 0; i < NR; i++) mem[1][i] = '0;
        #1;
        check("arst_ready", hreadyout[1], 1);
        check("arst_resp", hresp[1], 0);
        check("arst_rdata", hrdata[1], 0);
        check("arst_regs", rego[1], 0);
        @(posedge clk); #1 rstn[1] = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("arst_strobe", strobe[1], 0);
        check("arst_discard", rego[1], 0);

        for (int r = 0; r < 40; r++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                int sz;
                logic [31:0] a;
                sz = ($urandom_range(0, 9) > 7) ? $urandom_range(3, 7) : $urandom_range(0, 2);
                a = $urandom_range(0, 4 * NR + 7);
                if ($urandom_range(0, 3) != 0 && sz <= 2) a = a & ~((32'd1 << sz) - 32'd1);
                set_t(k, 1'($urandom_range(0, 1)), a, sz, $urandom);
            end
            run_seq(r % 2, n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
